prelude_core: RTL and testbench

//  Parametrised multi-cycle successor of the prelude 8-bit core; one instruction per FETCH/EXEC pass.

---
 rtl/prelude_core.sv | 182 ++++++++++++++++++
 tb/tb_prelude_core.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prelude_core.sv
// prelude_core: multi-cycle accumulator-style core. Each instruction takes one
// FETCH/EXEC pass. Instruction fetch goes through a req/valid memory port, and
// byte I/O goes through valid/ready handshakes on register index 7.
module prelude_core #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_valid,
  input  logic [DATA_W+1:0] imem_data,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              halted
);

  typedef enum logic [2:0] {StFetch, StExec, StIoRd, StIoWr, StHalt} state_e;

  state_e            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W+1:0] r_ir;
  logic [DATA_W-1:0] r_regs [0:6];
  logic [DATA_W-1:0] r_out_data;

  logic [1:0]        w_op;
  logic [2:0]        w_src;
  logic [2:0]        w_dst;
  logic [DATA_W-1:0] w_src_val;
  logic [DATA_W-1:0] w_calc;
  logic              w_taken;
  logic              w_r3_neg;
  logic              w_r3_zero;
  logic [ADDR_W-1:0] w_target;
  logic [ADDR_W-1:0] w_pc_inc;

  assign w_op      = r_ir[DATA_W+1:DATA_W];
  assign w_src     = r_ir[5:3];
  assign w_dst     = r_ir[2:0];
  assign w_pc_inc  = r_pc + 1'b1;
  assign w_r3_neg  = r_regs[3][DATA_W-1];
  assign w_r3_zero = (r_regs[3] == '0);

  // Branch target is r0 resized to the address width
  if (ADDR_W <= DATA_W) begin : g_target_trunc
    assign w_target = r_regs[0][ADDR_W-1:0];
  end else begin : g_target_ext
    assign w_target = {{(ADDR_W - DATA_W){1'b0}}, r_regs[0]};
  end

  // COPY source operand; index 7 is the I/O port and never read from storage
  always_comb begin
    w_src_val = '0;
    if (w_src != 3'd7) begin
      w_src_val = r_regs[w_src];
    end
  end

  // CALC result, modulo 2^DATA_W
  always_comb begin
    w_calc = '0;
    unique case (r_ir[2:0])
      3'd0: w_calc = r_regs[1] | r_regs[2];
      3'd1: w_calc = ~(r_regs[1] & r_regs[2]);
      3'd2: w_calc = ~(r_regs[1] | r_regs[2]);
      3'd3: w_calc = r_regs[1] & r_regs[2];
      3'd4: w_calc = r_regs[1] + r_regs[2];
      3'd5: w_calc = r_regs[1] - r_regs[2];
      3'd6: w_calc = r_regs[1] ^ r_regs[2];
      3'd7: w_calc = {r_regs[1][DATA_W-2:0], 1'b0};
      default: w_calc = '0;
    endcase
  end

  // Branch condition on r3 treated as signed
  always_comb begin
    w_taken = 1'b0;
    unique case (r_ir[2:0])
      3'd0: w_taken = 1'b0;
      3'd1: w_taken = w_r3_zero;
      3'd2: w_taken = w_r3_neg;
      3'd3: w_taken = w_r3_neg | w_r3_zero;
      3'd4: w_taken = 1'b1;
      3'd5: w_taken = ~w_r3_zero;
      3'd6: w_taken = ~w_r3_neg;
      3'd7: w_taken = ~w_r3_neg & ~w_r3_zero;
      default: w_taken = 1'b0;
    endcase
  end

  // Core FSM: fetch, execute, I/O handshakes and halt
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= StFetch;
      r_pc       <= '0;
      r_ir       <= '0;
      r_out_data <= '0;
      for (int i = 0; i < 7; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      unique case (r_state)
        StFetch: begin
          if (imem_valid) begin
            r_ir    <= imem_data;
            r_state <= StExec;
          end
        end
        StExec: begin
          unique case (w_op)
            2'b00: begin
              r_regs[0] <= r_ir[DATA_W-1:0];
              r_pc      <= w_pc_inc;
              r_state   <= StFetch;
            end
            2'b01: begin
              r_regs[3] <= w_calc;
              r_pc      <= w_pc_inc;
              r_state   <= StFetch;
            end
            2'b10: begin
              if (w_src == 3'd7) begin
                r_state <= StIoRd;
              end else if (w_dst == 3'd7) begin
                r_out_data <= w_src_val;
                r_state    <= StIoWr;
              end else begin
                r_regs[w_dst] <= w_src_val;
                r_pc          <= w_pc_inc;
                r_state       <= StFetch;
              end
            end
            2'b11: begin
              if (r_ir[5]) begin
                r_state <= StHalt;
              end else begin
                r_pc    <= w_taken ? w_target : w_pc_inc;
                r_state <= StFetch;
              end
            end
            default: r_state <= StFetch;
          endcase
        end
        StIoRd: begin
          if (in_valid) begin
            if (w_dst == 3'd7) begin
              // Input forwarded straight to the output port
              r_out_data <= in_data;
              r_state    <= StIoWr;
            end else begin
              r_regs[w_dst] <= in_data;
              r_pc          <= w_pc_inc;
              r_state       <= StFetch;
            end
          end
        end
        StIoWr: begin
          if (out_ready) begin
            r_pc    <= w_pc_inc;
            r_state <= StFetch;
          end
        end
        StHalt: r_state <= StHalt;
        default: r_state <= StFetch;
      endcase
    end
  end

  // Outputs are gated by reset so they read 0 while reset is held low
  assign imem_req  = reset & (r_state == StFetch);
  assign imem_addr = r_pc;
  assign in_ready  = reset & (r_state == StIoRd) & in_valid;
  assign out_valid = reset & (r_state == StIoWr);
  assign out_data  = r_out_data;
  assign halted    = reset & (r_state == StHalt);

endmodule

// File: tb/tb_prelude_core.sv
// Self-checking bench for prelude_core (DATA_W=8, ADDR_W=8).
module tb_prelude_core;
  localparam int DW = 8;
  localparam int AW = 8;
  localparam logic [DW+1:0] HaltInstr = 10'h320;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_valid;
  logic [DW+1:0] imem_data;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready = 1'b1;
  logic          halted;

  logic [DW+1:0] mem [256];
  logic          imem_en = 1'b1;

  int n_pass  = 0;
  int n_total = 0;

  assign imem_valid = imem_req & imem_en;
  assign imem_data  = mem[imem_addr];

  always #5 clk = ~clk;

  prelude_core #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_valid(imem_valid),
    .imem_data (imem_data),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .halted    (halted)
  );

  function automatic logic [9:0] f_imm(input logic [7:0] v);
    return {2'b00, v};
  endfunction
  function automatic logic [9:0] f_calc(input logic [2:0] f);
    return {2'b01, 5'b0, f};
  endfunction
  function automatic logic [9:0] f_copy(input logic [2:0] s, input logic [2:0] d);
    return {2'b10, 2'b00, s, d};
  endfunction
  function automatic logic [9:0] f_br(input logic [2:0] c);
    return {2'b11, 5'b0, c};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = HaltInstr;
  endtask

  // Hold reset two cycles, release on a falling edge
  task automatic start();
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Wait (bounded) for out_valid; returns X on timeout so the following check fails
  task automatic wait_out(output logic [7:0] d);
    d = 'x;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (out_valid) begin
        d = out_data;
        break;
      end
    end
  endtask

  typedef struct {
    string      name;
    logic [2:0] f;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
  } calc_vec_t;

  typedef struct {
    logic [7:0] r3;
    logic [2:0] cond;
    logic       taken;
  } br_vec_t;

  calc_vec_t calc_tbl [8];
  br_vec_t   br_tbl [13];

  initial begin
    logic [7:0] d;
    int         good;
    logic [7:0] held;

    calc_tbl[0] = '{"or",   3'd0, 8'hA0, 8'h05, 8'hA5};
    calc_tbl[1] = '{"nand", 3'd1, 8'hF0, 8'h3C, 8'hCF};
    calc_tbl[2] = '{"nor",  3'd2, 8'h0F, 8'h30, 8'hC0};
    calc_tbl[3] = '{"and",  3'd3, 8'hF0, 8'h3C, 8'h30};
    calc_tbl[4] = '{"add",  3'd4, 8'h80, 8'h81, 8'h01};
    calc_tbl[5] = '{"sub",  3'd5, 8'h10, 8'h20, 8'hF0};
    calc_tbl[6] = '{"xor",  3'd6, 8'hFF, 8'h0F, 8'hF0};
    calc_tbl[7] = '{"shl",  3'd7, 8'hC3, 8'h55, 8'h86};

    br_tbl[0]  = '{8'h01, 3'd2, 1'b0};
    br_tbl[1]  = '{8'h01, 3'd7, 1'b1};
    br_tbl[2]  = '{8'h00, 3'd1, 1'b1};
    br_tbl[3]  = '{8'h80, 3'd2, 1'b1};
    br_tbl[4]  = '{8'h00, 3'd3, 1'b1};
    br_tbl[5]  = '{8'h01, 3'd3, 1'b0};
    br_tbl[6]  = '{8'h80, 3'd6, 1'b0};
    br_tbl[7]  = '{8'h00, 3'd6, 1'b1};
    br_tbl[8]  = '{8'h00, 3'd7, 1'b0};
    br_tbl[9]  = '{8'h80, 3'd7, 1'b0};
    br_tbl[10] = '{8'h01, 3'd5, 1'b1};
    br_tbl[11] = '{8'h00, 3'd0, 1'b0};
    br_tbl[12] = '{8'h00, 3'd4, 1'b1};

    // Reset state: all outputs low even with in_valid asserted
    clear_mem();
    reset    = 1'b0;
    in_valid = 1'b1;
    #12;
    check("rst_imem_req", imem_req, 0);
    check("rst_imem_addr", imem_addr, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_halted", halted, 0);
    in_valid = 1'b0;

    // IMM 0xA5, COPY r0->r1: pc=2 after 4 cycles
    clear_mem();
    mem[0] = f_imm(8'hA5);
    mem[1] = f_copy(3'd0, 3'd1);
    mem[2] = f_copy(3'd1, 3'd7);
    mem[3] = f_copy(3'd0, 3'd7);
    start();
    repeat (4) @(posedge clk);
    #1 check("latency_pc2", imem_addr, 8'h02);
    wait_out(d);
    check("copy_r1", d, 8'hA5);
    wait_out(d);
    check("copy_r0", d, 8'hA5);

    // CALC table: r1=a, r2=b, CALC f, r3 out
    for (int i = 0; i < 8; i++) begin
      clear_mem();
      mem[0] = f_imm(calc_tbl[i].a);
      mem[1] = f_copy(3'd0, 3'd1);
      mem[2] = f_imm(calc_tbl[i].b);
      mem[3] = f_copy(3'd0, 3'd2);
      mem[4] = f_calc(calc_tbl[i].f);
      mem[5] = f_copy(3'd3, 3'd7);
      start();
      wait_out(d);
      check({"calc_", calc_tbl[i].name}, d, calc_tbl[i].exp);
    end

    // Branch table: not-taken path emits 0x11, taken path (0x40) emits 0x22
    for (int i = 0; i < 13; i++) begin
      clear_mem();
      mem[0]     = f_imm(br_tbl[i].r3);
      mem[1]     = f_copy(3'd0, 3'd1);
      mem[2]     = f_imm(8'h00);
      mem[3]     = f_copy(3'd0, 3'd2);
      mem[4]     = f_calc(3'd0);
      mem[5]     = f_imm(8'h40);
      mem[6]     = f_br(br_tbl[i].cond);
      mem[7]     = f_imm(8'h11);
      mem[8]     = f_copy(3'd0, 3'd7);
      mem[8'h40] = f_imm(8'h22);
      mem[8'h41] = f_copy(3'd0, 3'd7);
      start();
      wait_out(d);
      check($sformatf("br_c%0d_r3_%02h", br_tbl[i].cond, br_tbl[i].r3), d,
            br_tbl[i].taken ? 8'h22 : 8'h11);
    end

    // Output stall: out_ready low for 5 cycles
    clear_mem();
    mem[0] = f_imm(8'h5C);
    mem[1] = f_copy(3'd0, 3'd1);
    mem[2] = f_copy(3'd1, 3'd7);
    out_ready = 1'b0;
    start();
    wait_out(d);
    check("stall_first", d, 8'h5C);
    good = (out_valid && out_data == 8'h5C && imem_addr == 8'h02) ? 1 : 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (out_valid && out_data == 8'h5C && imem_addr == 8'h02 && !imem_req) good++;
    end
    check("stall_hold_cycles", good, 5);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("stall_release_valid", out_valid, 0);
    check("stall_release_pc", imem_addr, 8'h03);

    // COPY 7->7 with in_valid 3 cycles late, then COPY 7->r4 and r4->7
    clear_mem();
    mem[0] = f_copy(3'd7, 3'd7);
    mem[1] = f_copy(3'd7, 3'd4);
    mem[2] = f_copy(3'd4, 3'd7);
    start();
    good = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (!in_ready && !out_valid) good++;
    end
    check("in_wait_idle", good, 3);
    in_valid = 1'b1;
    in_data  = 8'h3C;
    #1 check("in_ready_high", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("in_ready_one_cycle", in_ready, 0);
    check("io_fwd_valid", out_valid, 1);
    check("io_fwd_data", out_data, 8'h3C);
    in_valid = 1'b1;
    in_data  = 8'h96;
    wait_out(d);
    check("io_r4_roundtrip", d, 8'h96);
    in_valid = 1'b0;

    // HALT at pc=0x10
    clear_mem();
    for (int i = 2; i < 16; i++) mem[i] = f_imm(8'h77);
    mem[0] = f_imm(8'h10);
    mem[1] = f_br(3'd4);
    start();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (halted) break;
    end
    check("halt_flag", halted, 1);
    check("halt_pc", imem_addr, 8'h10);
    good = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (halted && !imem_req && imem_addr == 8'h10 && !out_valid && !in_ready) good++;
    end
    check("halt_frozen", good, 5);

    // Reset asserted during IO_WR
    clear_mem();
    mem[0] = f_imm(8'h33);
    mem[1] = f_copy(3'd0, 3'd7);
    out_ready = 1'b0;
    start();
    wait_out(d);
    check("pre_reset_out", d, 8'h33);
    #2 reset = 1'b0;
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_req", imem_req, 0);
    @(negedge clk);
    reset     = 1'b1;
    out_ready = 1'b1;
    #1;
    check("post_rst_addr", imem_addr, 8'h00);
    check("post_rst_req", imem_req, 1);
    wait_out(d);
    check("post_rst_rerun", d, 8'h33);

    // pc wrap 0xFF -> 0x00 on a non-branch instruction
    clear_mem();
    mem[0]     = f_imm(8'hFF);
    mem[1]     = f_br(3'd4);
    mem[8'hFF] = f_imm(8'h5A);
    start();
    held = 8'h00;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (imem_req && imem_addr == 8'hFF) begin
        held = 8'hFF;
        break;
      end
    end
    check("wrap_reach_ff", held, 8'hFF);
    repeat (2) @(posedge clk);
    #1;
    check("wrap_addr", imem_addr, 8'h00);
    check("wrap_req", imem_req, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

endmodule
